// File: rtl/bridge_arbiter_pkg.sv
// Shared encodings and default parameters for the single-lane bridge arbiter.
// dir_of maps an FSM state to the direction code driven on the dir output.
package bridge_arbiter_pkg;

  localparam int MAX_BURST_DEF    = 4;
  localparam int MAX_OCC_DEF      = 7;
  localparam int CLEAR_CYCLES_DEF = 3;
  localparam int OCC_W_DEF        = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_E_GO    = 3'd1,
    ST_E_DRAIN = 3'd2,
    ST_W_GO    = 3'd3,
    ST_W_DRAIN = 3'd4,
    ST_CLEAR   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'b00,
    DIR_EAST  = 2'b01,
    DIR_WEST  = 2'b10,
    DIR_CLEAR = 2'b11
  } dir_e;

  function automatic dir_e dir_of(state_e s);
    case (s)
      ST_E_GO, ST_E_DRAIN: return DIR_EAST;
      ST_W_GO, ST_W_DRAIN: return DIR_WEST;
      ST_CLEAR:            return DIR_CLEAR;
      default:             return DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/bridge_arbiter_clear_timer.sv
// Clearance gap timer: load arms it with CYCLES, then it counts down once per clock.
// done_o rises in the last cycle of the gap so the owner leaves CLEAR after exactly CYCLES cycles.
module bridge_arbiter_clear_timer
  import bridge_arbiter_pkg::*;
#(
  parameter int CYCLES = CLEAR_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic done_o
);

  localparam int W = (CYCLES < 2) ? 1 : $clog2(CYCLES + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = W'(CYCLES);
    else if (cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q <= W'(1));

endmodule

// File: rtl/bridge_arbiter.sv
// Single-lane E/W arbiter: one-at-a-time grants, direction lock, burst fairness,
// occupancy tracking from exit pulses and a clearance gap before reversing direction.
module bridge_arbiter
  import bridge_arbiter_pkg::*;
#(
  parameter int MAX_BURST    = MAX_BURST_DEF,
  parameter int MAX_OCC      = MAX_OCC_DEF,
  parameter int CLEAR_CYCLES = CLEAR_CYCLES_DEF,
  parameter int OCC_W        = OCC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             e_req,
  input  logic             w_req,
  input  logic             exit_p,
  output logic             e_gnt,
  output logic             w_gnt,
  output logic [1:0]       dir,
  output logic             idle,
  output logic [OCC_W-1:0] occ,
  output logic             err,
  output logic [2:0]       dbg_state
);

  localparam int BURST_W = $clog2(MAX_BURST + 1);

  // Handshake: a req is held until its one-cycle gnt pulse; a req still high two
  // cycles after the grant is a fresh request. exit_p is a one-cycle event pulse.
  state_e             state_q, state_d;
  dir_e               dir_q, dir_d, last_dir_q, last_dir_d;
  logic               e_gnt_q, e_gnt_d, w_gnt_q, w_gnt_d;
  logic               idle_q, idle_d, err_q, err_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               burst_full, occ_room, occ_empty, exit_ok, go_entry;
  logic               tmr_load, tmr_done;

  assign burst_full = (burst_q == BURST_W'(MAX_BURST));
  assign occ_room   = (occ_q < OCC_W'(MAX_OCC));
  assign occ_empty  = (occ_q == '0);
  assign exit_ok    = exit_p && !occ_empty;
  assign tmr_load   = (state_d == ST_CLEAR) && (state_q != ST_CLEAR);
  assign go_entry   = (state_d != state_q) && (state_d == ST_E_GO || state_d == ST_W_GO);

  bridge_arbiter_clear_timer #(.CYCLES(CLEAR_CYCLES)) u_clear_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (tmr_load),
    .done_o (tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      e_gnt_q    <= 1'b0;
      w_gnt_q    <= 1'b0;
      dir_q      <= DIR_NONE;
      idle_q     <= 1'b1;
      occ_q      <= '0;
      err_q      <= 1'b0;
      burst_q    <= '0;
      last_dir_q <= DIR_WEST;
    end else begin
      state_q    <= state_d;
      e_gnt_q    <= e_gnt_d;
      w_gnt_q    <= w_gnt_d;
      dir_q      <= dir_d;
      idle_q     <= idle_d;
      occ_q      <= occ_d;
      err_q      <= err_d;
      burst_q    <= burst_d;
      last_dir_q <= last_dir_d;
    end
  end

  // Returning to IDLE also waits for an in-flight grant, so occ never lags the state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (e_req && w_req)
          state_d = (last_dir_q == DIR_WEST) ? ST_E_GO : ST_W_GO;
        else if (e_req)
          state_d = ST_E_GO;
        else if (w_req)
          state_d = ST_W_GO;
      end
      ST_E_GO: begin
        if (w_req && (burst_full || !e_req))
          state_d = ST_E_DRAIN;
        else if (!e_req && !w_req && occ_empty && !e_gnt_q)
          state_d = ST_IDLE;
      end
      ST_W_GO: begin
        if (e_req && (burst_full || !w_req))
          state_d = ST_W_DRAIN;
        else if (!e_req && !w_req && occ_empty && !w_gnt_q)
          state_d = ST_IDLE;
      end
      ST_E_DRAIN, ST_W_DRAIN: begin
        if (occ_empty)
          state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (tmr_done) begin
          if (last_dir_q == DIR_EAST)
            state_d = w_req ? ST_W_GO : ST_IDLE;
          else
            state_d = e_req ? ST_E_GO : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    e_gnt_d = (state_q == ST_E_GO) && e_req && occ_room && !burst_full && !e_gnt_q;
    w_gnt_d = (state_q == ST_W_GO) && w_req && occ_room && !burst_full && !w_gnt_q;

    burst_d = burst_q;
    if (go_entry)
      burst_d = '0;
    else if (e_gnt_d || w_gnt_d)
      burst_d = burst_q + BURST_W'(1);
    else if (burst_full && ((state_q == ST_E_GO && !w_req) || (state_q == ST_W_GO && !e_req)))
      burst_d = '0;

    last_dir_d = last_dir_q;
    if (tmr_load)
      last_dir_d = (state_q == ST_E_DRAIN) ? DIR_EAST : DIR_WEST;

    // Grants are counted from the registered pulse, i.e. one cycle after they appear.
    occ_d = occ_q;
    case ({e_gnt_q || w_gnt_q, exit_ok})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
    err_d = err_q || (exit_p && occ_empty);

    dir_d  = dir_of(state_d);
    idle_d = (state_d == ST_IDLE);
  end

  assign e_gnt     = e_gnt_q;
  assign w_gnt     = w_gnt_q;
  assign dir       = dir_q;
  assign idle      = idle_q;
  assign occ       = occ_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bridge_arbiter.sv
// Bench for bridge_arbiter: directed scenarios with hand-computed expectations plus a
// randomized run, all checked every cycle against a side-symmetric behavioural model.
module tb_bridge_arbiter;

  localparam int MAX_BURST    = 4;
  localparam int MAX_OCC      = 7;
  localparam int CLEAR_CYCLES = 3;

  localparam int M_IDLE  = 0;
  localparam int M_GO    = 1;
  localparam int M_DRAIN = 2;
  localparam int M_CLEAR = 3;

  logic       clk, rst_n, e_req, w_req, exit_p;
  logic       e_gnt, w_gnt, idle, err;
  logic [1:0] dir;
  logic [2:0] occ, dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;

  bridge_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .e_req     (e_req),
    .w_req     (w_req),
    .exit_p    (exit_p),
    .e_gnt     (e_gnt),
    .w_gnt     (w_gnt),
    .dir       (dir),
    .idle      (idle),
    .occ       (occ),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Sides are 1 (east) and 2 (west); the opposite side is 3 - side.
  int   m_mode, m_side, m_last, m_burst, m_left, m_occ;
  int   n_mode, n_side, n_last, n_burst, n_left, n_occ;
  logic m_gnt [1:2];
  logic n_gnt [1:2];
  logic m_err, n_err;

  function automatic logic req_of(int s, logic e, logic w);
    return (s == 1) ? e : w;
  endfunction

  always_comb begin
    n_mode   = m_mode;
    n_side   = m_side;
    n_last   = m_last;
    n_burst  = m_burst;
    n_left   = m_left;
    n_gnt[1] = 1'b0;
    n_gnt[2] = 1'b0;
    n_err    = m_err || (exit_p && m_occ == 0);
    n_occ    = m_occ + ((m_gnt[1] || m_gnt[2]) ? 1 : 0) - ((exit_p && m_occ > 0) ? 1 : 0);
    case (m_mode)
      M_IDLE: begin
        if (e_req || w_req) begin
          n_mode  = M_GO;
          n_burst = 0;
          if (e_req && w_req) n_side = 3 - m_last;
          else                n_side = e_req ? 1 : 2;
        end
      end
      M_GO: begin
        if (req_of(m_side, e_req, w_req) && m_occ < MAX_OCC && m_burst < MAX_BURST && !m_gnt[m_side]) begin
          n_gnt[m_side] = 1'b1;
          n_burst       = m_burst + 1;
        end else if (req_of(3 - m_side, e_req, w_req) &&
                     (m_burst == MAX_BURST || !req_of(m_side, e_req, w_req))) begin
          n_mode = M_DRAIN;
        end else if (!e_req && !w_req && m_occ == 0 && !m_gnt[m_side]) begin
          n_mode = M_IDLE;
          n_side = 0;
        end else if (m_burst == MAX_BURST && !req_of(3 - m_side, e_req, w_req)) begin
          n_burst = 0;
        end
      end
      M_DRAIN: begin
        if (m_occ == 0) begin
          n_mode = M_CLEAR;
          n_last = m_side;
          n_left = CLEAR_CYCLES;
        end
      end
      default: begin
        n_left = m_left - 1;
        if (m_left <= 1) begin
          if (req_of(3 - m_last, e_req, w_req)) begin
            n_mode  = M_GO;
            n_side  = 3 - m_last;
            n_burst = 0;
          end else begin
            n_mode = M_IDLE;
            n_side = 0;
          end
        end
      end
    endcase
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode   <= M_IDLE;
      m_side   <= 0;
      m_last   <= 2;
      m_burst  <= 0;
      m_left   <= 0;
      m_occ    <= 0;
      m_gnt[1] <= 1'b0;
      m_gnt[2] <= 1'b0;
      m_err    <= 1'b0;
    end else begin
      m_mode   <= n_mode;
      m_side   <= n_side;
      m_last   <= n_last;
      m_burst  <= n_burst;
      m_left   <= n_left;
      m_occ    <= n_occ;
      m_gnt[1] <= n_gnt[1];
      m_gnt[2] <= n_gnt[2];
      m_err    <= n_err;
    end
  end

  function automatic logic [1:0] model_dir(int mode, int side);
    if (mode == M_IDLE)  return 2'b00;
    if (mode == M_CLEAR) return 2'b11;
    return (side == 1) ? 2'b01 : 2'b10;
  endfunction

  // ---------------- scoreboard / compare ----------------
  logic [8:0] exp_q[$];
  logic [8:0] act_v, exp_v;

  always @(negedge clk) begin
    if (chk_en) begin
      exp_q.push_back({m_gnt[1], m_gnt[2], model_dir(m_mode, m_side), (m_mode == M_IDLE), 3'(m_occ), m_err});
      act_v = {e_gnt, w_gnt, dir, idle, occ, err};
      exp_v = exp_q.pop_front();
      n_checks++;
      if (act_v === exp_v)
        n_pass++;
      else
        $display("FAIL cycle_compare t=%0t got egnt=%b wgnt=%b dir=%b idle=%b occ=%0d err=%b want egnt=%b wgnt=%b dir=%b idle=%b occ=%0d err=%b",
                 $time, act_v[8], act_v[7], act_v[6:5], act_v[4], act_v[3:1], act_v[0],
                 exp_v[8], exp_v[7], exp_v[6:5], exp_v[4], exp_v[3:1], exp_v[0]);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s got=0x%0h want=0x%0h t=%0t", name, act, expv, $time);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    e_req  = 1'b0;
    w_req  = 1'b0;
    exit_p = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [20:0] mask;
  int          cnt_e, cnt_clear, w_at;
  bit          seen;

  initial begin
    e_req = 1'b0; w_req = 1'b0; exit_p = 1'b0; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    check("reset_state", {23'd0, e_gnt, w_gnt, dir, idle, occ, err}, {23'd0, 9'b0_0_00_1_000_0});

    // East held alone: grants every other cycle, burst refills, occ stalls at MAX_OCC.
    do_reset();
    @(negedge clk);
    e_req = 1'b1;
    mask  = '0;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      mask[c] = e_gnt;
    end
    check("held_east_grant_pattern", {11'd0, mask}, {11'd0, 21'h002AAA});
    check("held_east_occ_stall", {29'd0, occ}, 32'd7);
    check("held_east_dir", {30'd0, dir}, 32'd1);

    // Both requests together: east first, burst of 4, drain, clear gap, then west.
    do_reset();
    @(negedge clk);
    e_req = 1'b1;
    w_req = 1'b1;
    cnt_e = 0; cnt_clear = 0; w_at = -1;
    for (int c = 0; c < 40 && w_at < 0; c++) begin
      @(negedge clk);
      if (e_gnt) cnt_e++;
      if (dir == 2'b11) cnt_clear++;
      if (w_gnt) w_at = c;
      exit_p = (c >= 9 && c <= 12);
    end
    e_req = 1'b0; w_req = 1'b0; exit_p = 1'b0;
    check("both_east_burst", cnt_e, 32'd4);
    check("both_clear_len", cnt_clear, 32'd3);
    check("both_first_west_cycle", w_at, 32'd18);

    // Grant and exit in the same cycle at occ=2, then async reset mid E_GO with occ=3.
    do_reset();
    @(negedge clk);
    e_req = 1'b1;
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      exit_p = 1'b0;
      if (c == 5) begin
        check("gnt_at_occ2", {28'd0, e_gnt, occ}, {28'd0, 1'b1, 3'd2});
        exit_p = 1'b1;
      end
      if (c == 6) check("gnt_exit_cancel", {29'd0, occ}, 32'd2);
      if (c == 9) check("pre_reset_go", {26'd0, e_gnt, dir, occ}, {26'd0, 1'b1, 2'b01, 3'd3});
    end
    #2 rst_n = 1'b0;
    e_req = 1'b0;
    #1 check("async_reset_mid_go", {23'd0, e_gnt, w_gnt, dir, idle, occ, err}, {23'd0, 9'b0_0_00_1_000_0});
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    w_req = 1'b1;
    seen  = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (w_gnt) seen = 1'b1;
    end
    w_req = 1'b0;
    check("post_reset_west_grant", {31'd0, seen}, 32'd1);
    check("post_reset_west_dir", {30'd0, dir}, 32'd2);

    // West request withdrawn during CLEAR: gap completes and arbiter idles.
    do_reset();
    @(negedge clk);
    e_req = 1'b1;
    seen  = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (e_gnt) seen = 1'b1;
    end
    e_req = 1'b0;
    w_req = 1'b1;
    @(negedge clk);
    exit_p = 1'b1;
    @(negedge clk);
    exit_p = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (dir == 2'b11) seen = 1'b1;
      else @(negedge clk);
    end
    check("clear_reached", {31'd0, seen}, 32'd1);
    w_req = 1'b0;
    repeat (5) @(negedge clk);
    check("clear_to_idle", {29'd0, idle, dir}, {29'd0, 1'b1, 2'b00});

    // Exit with nothing on the resource: ignored, sticky error until reset.
    do_reset();
    @(negedge clk);
    exit_p = 1'b1;
    @(negedge clk);
    exit_p = 1'b0;
    check("spurious_exit", {28'd0, occ, err}, {28'd0, 3'd0, 1'b1});
    repeat (5) @(negedge clk);
    check("err_sticky", {31'd0, err}, 32'd1);
    do_reset();
    @(negedge clk);
    check("err_cleared_by_reset", {31'd0, err}, 32'd0);

    // Randomized traffic; every cycle checked by the compare process.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (e_req) begin
        if (e_gnt) e_req = ($urandom_range(0, 3) == 0);
      end else begin
        e_req = ($urandom_range(0, 2) == 0);
      end
      if (w_req) begin
        if (w_gnt) w_req = ($urandom_range(0, 3) == 0);
      end else begin
        w_req = ($urandom_range(0, 2) == 0);
      end
      exit_p = (m_occ > 0) && ($urandom_range(0, 2) == 0);
    end
    e_req = 1'b0; w_req = 1'b0; exit_p = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
